// File: rtl/vga_scan_timing.sv
// VGA raster scan generator: pixel/line counters, blanking, sync outputs and line/frame pulses,
// with a configurable delay on the connector sync pins to match the downstream colour pipeline.
module vga_scan_timing #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int SYNC_DELAY      = 1
) (
    input  logic       vga_clk,
    input  logic       Reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_pin,
    output logic       vs_pin,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       hs_act, vs_act;

    // Every decode works on the next-state counters so the registered flags line up with DrawX/DrawY.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        hc_d          = hc_q + 10'd1;
        vc_d          = vc_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (hc_q == H_LAST) begin
            hc_d         = '0;
            line_start_d = 1'b1;
            if (vc_q == V_LAST) begin
                vc_d          = '0;
                frame_start_d = 1'b1;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end

        hs_act  = (int'(hc_d) >= HS_START) && (int'(hc_d) < HS_END);
        vs_act  = (int'(vc_d) >= VS_START) && (int'(vc_d) < VS_END);
        hs_d    = hs_act ? ~SYNC_IDLE : SYNC_IDLE;
        vs_d    = vs_act ? ~SYNC_IDLE : SYNC_IDLE;
        blank_d = (int'(hc_d) < H_VISIBLE) && (int'(vc_d) < V_VISIBLE);
    end

    always_ff @(posedge vga_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (Reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            blank_q       <= 1'b1;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs_pin = hs_q;
            assign vs_pin = vs_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d    = hs_pipe_q;
                vs_pipe_d    = vs_pipe_q;
                hs_pipe_d[0] = hs_q;
                vs_pipe_d[0] = vs_q;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            always_ff @(posedge vga_clk) begin
                // NOTE: the delay line is reset like any other state, so no stale pulse reaches the pins.
                if (Reset) begin
                    hs_pipe_q <= {SYNC_DELAY{SYNC_IDLE}};
                    vs_pipe_q <= {SYNC_DELAY{SYNC_IDLE}};
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hs_pin = hs_pipe_q[SYNC_DELAY-1];
            assign vs_pin = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: three configurations driven from one clock/reset, each compared
// every cycle against an arithmetic raster model (position = edges since reset release).
module tb_vga_scan_timing;

    localparam int N = 3;  // 0: defaults, 1: short frame + 3-deep pin delay, 2: tiny active-high

    logic vga_clk;
    logic Reset;

    logic [9:0] dflt_x, dflt_y, midv_x, midv_y, small_x, small_y;
    logic dflt_blank, dflt_hs, dflt_vs, dflt_hsp, dflt_vsp, dflt_ls, dflt_fs;
    logic midv_blank, midv_hs, midv_vs, midv_hsp, midv_vsp, midv_ls, midv_fs;
    logic small_blank, small_hs, small_vs, small_hsp, small_vsp, small_ls, small_fs;

    vga_scan_timing u_dflt (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(dflt_x), .DrawY(dflt_y), .blank(dflt_blank),
        .hs(dflt_hs), .vs(dflt_vs), .hs_pin(dflt_hsp), .vs_pin(dflt_vsp),
        .line_start(dflt_ls), .frame_start(dflt_fs)
    );

    vga_scan_timing #(
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(3)
    ) u_midv (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(midv_x), .DrawY(midv_y), .blank(midv_blank),
        .hs(midv_hs), .vs(midv_vs), .hs_pin(midv_hsp), .vs_pin(midv_vsp),
        .line_start(midv_ls), .frame_start(midv_fs)
    );

    vga_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0), .SYNC_DELAY(0)
    ) u_small (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(small_x), .DrawY(small_y), .blank(small_blank),
        .hs(small_hs), .vs(small_vs), .hs_pin(small_hsp), .vs_pin(small_vsp),
        .line_start(small_ls), .frame_start(small_fs)
    );

    logic [26:0] obs [N];
    assign obs[0] = {dflt_x, dflt_y, dflt_blank, dflt_hs, dflt_vs, dflt_hsp, dflt_vsp, dflt_ls, dflt_fs};
    assign obs[1] = {midv_x, midv_y, midv_blank, midv_hs, midv_vs, midv_hsp, midv_vsp, midv_ls, midv_fs};
    assign obs[2] = {small_x, small_y, small_blank, small_hs, small_vs, small_hsp, small_vsp, small_ls, small_fs};

    int hv  [N] = '{640, 640, 8};
    int hf  [N] = '{16, 16, 2};
    int hsw [N] = '{96, 96, 2};
    int hb  [N] = '{48, 48, 2};
    int vv  [N] = '{480, 8, 4};
    int vf  [N] = '{10, 2, 1};
    int vsw [N] = '{2, 2, 1};
    int vb  [N] = '{33, 3, 1};
    int sal [N] = '{1, 1, 0};
    int dly [N] = '{1, 3, 0};

    longint t [N];          // edges since the last reset release
    logic hist_hs [N][4];   // [0] = sync level one edge ago
    logic hist_vs [N][4];

    int checks   = 0;
    int failures = 0;

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] expect_vec(input int k);
        longint ht, vt, x, y;
        logic hs_act, vs_act, hs_l, vs_l, bl, ls, fs, hsp, vsp;
        ht = longint'(hv[k] + hf[k] + hsw[k] + hb[k]);
        vt = longint'(vv[k] + vf[k] + vsw[k] + vb[k]);
        x  = t[k] % ht;
        y  = (t[k] / ht) % vt;
        hs_act = (x >= hv[k] + hf[k]) && (x < hv[k] + hf[k] + hsw[k]);
        vs_act = (y >= vv[k] + vf[k]) && (y < vv[k] + vf[k] + vsw[k]);
        hs_l = (sal[k] != 0) ? !hs_act : hs_act;
        vs_l = (sal[k] != 0) ? !vs_act : vs_act;
        bl   = (x < hv[k]) && (y < vv[k]);
        ls   = (t[k] > 0) && (x == 0);
        fs   = ls && (y == 0);
        hsp  = (dly[k] == 0) ? hs_l : hist_hs[k][dly[k]-1];
        vsp  = (dly[k] == 0) ? vs_l : hist_vs[k][dly[k]-1];
        return {x[9:0], y[9:0], bl, hs_l, vs_l, hsp, vsp, ls, fs};
    endfunction

    task automatic model_edge(input logic rst);
        logic [26:0] e;
        for (int k = 0; k < N; k++) begin
            e = expect_vec(k);
            if (rst) begin
                t[k] = 0;
                for (int i = 0; i < 4; i++) begin
                    hist_hs[k][i] = (sal[k] != 0);
                    hist_vs[k][i] = (sal[k] != 0);
                end
            end else begin
                for (int i = 3; i > 0; i--) begin
                    hist_hs[k][i] = hist_hs[k][i-1];
                    hist_vs[k][i] = hist_vs[k][i-1];
                end
                hist_hs[k][0] = e[5];
                hist_vs[k][0] = e[4];
                t[k]++;
            end
        end
    endtask

    // One clock: update the model on the edge, compare every instance on the falling edge.
    task automatic step();
        @(posedge vga_clk);
        model_edge(Reset);
        @(negedge vga_clk);
        for (int k = 0; k < N; k++)
            check($sformatf("cycle_u%0d_t%0d", k, t[k]), 32'(obs[k]), 32'(expect_vec(k)));
    endtask

    initial begin
        int n, hs_low, first_hs, last_hs, first_hsp, blank_fall, vs_low;
        int hs_hi, vs_hi, hx_min, hx_max, vy_min, vy_max;

        for (int k = 0; k < N; k++) t[k] = 0;
        Reset = 1'b1;
        repeat (5) step();
        check("rst_x", 32'(dflt_x), 32'd0);
        check("rst_y", 32'(dflt_y), 32'd0);
        check("rst_blank", 32'(dflt_blank), 32'd1);
        check("rst_hs_vs", 32'({dflt_hs, dflt_vs, dflt_hsp, dflt_vsp}), 32'hF);
        check("rst_pulses", 32'({dflt_ls, dflt_fs}), 32'd0);
        check("rst_small_sync", 32'({small_hs, small_vs}), 32'd0);

        Reset = 1'b0;
        step();
        check("first_edge_x", 32'(dflt_x), 32'd1);

        hs_low = 0; first_hs = -1; last_hs = -1; first_hsp = -1; blank_fall = -1; n = 0;
        while (dflt_x != 10'd0 && n < 2000) begin
            if (!dflt_hs) begin
                hs_low++;
                if (first_hs < 0) first_hs = int'(dflt_x);
                last_hs = int'(dflt_x);
            end
            if (!dflt_hsp && first_hsp < 0) first_hsp = int'(dflt_x);
            if (!dflt_blank && blank_fall < 0) blank_fall = int'(dflt_x);
            step();
            n++;
        end
        check("line_wrap_seen", 32'(dflt_x), 32'd0);
        check("hs_low_count", 32'(hs_low), 32'd96);
        check("hs_first_low", 32'(first_hs), 32'd656);
        check("hs_last_low", 32'(last_hs), 32'd751);
        check("hs_pin_first_low", 32'(first_hsp), 32'd657);
        check("blank_fall_x", 32'(blank_fall), 32'd640);
        check("wrap_y", 32'(dflt_y), 32'd1);
        check("wrap_pulses", 32'({dflt_ls, dflt_fs}), 32'b10);

        n = 0;
        while (!midv_fs && n < 30000) begin step(); n++; end
        check("midv_fs_first_edge", 32'(t[1]), 32'd12000);
        check("midv_fs_with_ls", 32'(midv_ls), 32'd1);
        n = 0; vs_low = 0;
        do begin
            if (!midv_vs) vs_low++;
            step();
            n++;
        end while (!midv_fs && n < 30000);
        check("midv_frame_period", 32'(n), 32'd12000);
        check("midv_vs_low_count", 32'(vs_low), 32'd1600);

        n = 0;
        while (!small_fs && n < 200) begin step(); n++; end
        check("small_fs_seen", 32'(small_fs), 32'd1);
        n = 0; hs_hi = 0; vs_hi = 0; hx_min = 1000; hx_max = -1; vy_min = 1000; vy_max = -1;
        do begin
            if (small_hs) begin
                hs_hi++;
                if (int'(small_x) < hx_min) hx_min = int'(small_x);
                if (int'(small_x) > hx_max) hx_max = int'(small_x);
            end
            if (small_vs) begin
                vs_hi++;
                if (int'(small_y) < vy_min) vy_min = int'(small_y);
                if (int'(small_y) > vy_max) vy_max = int'(small_y);
            end
            step();
            n++;
        end while (!small_fs && n < 200);
        check("small_frame_period", 32'(n), 32'd98);
        check("small_hs_high_count", 32'(hs_hi), 32'd14);
        check("small_hs_window", 32'({hx_min[15:0], hx_max[15:0]}), {16'd10, 16'd11});
        check("small_vs_high_count", 32'(vs_hi), 32'd14);
        check("small_vs_window", 32'({vy_min[15:0], vy_max[15:0]}), {16'd5, 16'd5});

        n = 0;
        while (!(midv_x == 10'd700 && midv_y == 10'd11) && n < 13000) begin step(); n++; end
        check("midv_reach_700_11", 32'({midv_x, midv_y}), {12'd0, 10'd700, 10'd11});
        check("midv_sync_active", 32'({midv_hs, midv_vs, midv_hsp, midv_vsp}), 32'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_xy", 32'({midv_x, midv_y}), 32'd0);
        check("midrst_sync", 32'({midv_hs, midv_vs, midv_hsp, midv_vsp}), 32'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("midrst_no_residual_%0d", i), 32'({midv_hsp, midv_vsp}), 32'b11);
        end

        repeat (4) begin
            n = int'($urandom_range(50, 4000));
            repeat (n) step();
            Reset = 1'b1;
            repeat (int'($urandom_range(1, 3))) step();
            Reset = 1'b0;
        end
        repeat (3000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
